// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmitter with a one-entry holding register.
//
// Serialises one frame per accepted byte. The frame is a start bit (low), then
// DATA_BITS data bits LSB first, then an optional even parity bit, then
// STOP_BITS stop bits (high). Every line change happens on a sys_clk edge
// where baud_tick is high, so each bit lasts exactly one tick interval.
// A byte waiting in the holding register is loaded on the final stop-bit tick,
// which gives back-to-back frames with no idle gap.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even parity bit (XOR of the data bits)
//                      is sent between the last data bit and the first stop
//                      bit. When undefined, no parity state or logic exists.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..8)
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports:
//   sys_clk    in   system clock
//   reset_n    in   asynchronous active-low reset
//   baud_tick  in   one-cycle pulse per bit period
//   tx_data    in   byte to send, captured on acceptance
//   tx_valid   in   tx_data is valid
//   tx_ready   out  holding register empty (registered)
//   tx         out  serial line, registered, idle high
//   tx_busy    out  a frame is on the line (registered)
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int unsigned CntW = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic accept;
    logic bit_last;
    logic stop_last;

    // Holding register is a flop, so a byte accepted on a tick edge while idle
    // only starts its frame on the following tick.
    assign accept    = tx_valid && !hold_full_q;
    assign bit_last  = int'(bit_cnt_q) >= DATA_BITS - 1;
    assign stop_last = int'(stop_cnt_q) >= STOP_BITS - 1;

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (baud_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (hold_full_q) state_d = StStart;
                end
                StStart: state_d = StData;
                StData: begin
                    if (bit_last) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: state_d = StStop;
`endif
                StStop: begin
                    if (stop_last) state_d = hold_full_q ? StStart : StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath next values: holding register, shifter, counters, line.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        tx_d        = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (baud_tick) begin
            unique case (state_q)
                StIdle: begin
                    tx_d = 1'b1;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        tx_d        = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_d    = ^hold_q;
`endif
                    end
                end
                StStart: begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
                StData: begin
                    if (!bit_last) begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d       = parity_q;
`else
                        tx_d       = 1'b1;
`endif
                        stop_cnt_d = 1'b0;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
`endif
                StStop: begin
                    tx_d = 1'b1;
                    if (!stop_last) begin
                        stop_cnt_d = 1'b1;
                    end else if (hold_full_q) begin
                        // Back-to-back: next start bit begins on this tick.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        tx_d        = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_d    = ^hold_q;
`endif
                    end
                end
                default: tx_d = 1'b1;
            endcase
        end
    end

    assign busy_d = (state_d != StIdle);

    // Outputs come straight from flops.
    always_comb begin
        tx       = tx_q;
        tx_busy  = busy_q;
        tx_ready = !hold_full_q;
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int TICK = 217;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic [7:0] tx_data1 = 8'h00;
    logic [7:0] tx_data2 = 8'h00;
    logic       tx_valid1 = 1'b0;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready1, tx1, tx_busy1;
    logic       tx_ready2, tx2, tx_busy2;

    int n_vec = 0;
    int n_err = 0;

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut1 (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .baud_tick(baud_tick),
        .tx_data  (tx_data1),
        .tx_valid (tx_valid1),
        .tx_ready (tx_ready1),
        .tx       (tx1),
        .tx_busy  (tx_busy1)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .baud_tick(baud_tick),
        .tx_data  (tx_data2),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready2),
        .tx       (tx2),
        .tx_busy  (tx_busy2)
    );

    always #5 sys_clk = ~sys_clk;

    // One-cycle tick every TICK cycles, driven on the falling edge.
    initial begin
        forever begin
            repeat (TICK - 1) @(negedge sys_clk);
            baud_tick = 1'b1;
            @(negedge sys_clk);
            baud_tick = 1'b0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic get_tx(input int sel);
        return (sel != 0) ? tx2 : tx1;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? tx_busy2 : tx_busy1;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel != 0) ? tx_ready2 : tx_ready1;
    endfunction

    // Offer a byte and return on the falling edge after it was accepted.
    task automatic send(input int sel, input logic [7:0] d);
        @(negedge sys_clk);
        if (sel != 0) begin tx_valid2 = 1'b1; tx_data2 = d; end
        else          begin tx_valid1 = 1'b1; tx_data1 = d; end
        for (int i = 0; i < 5000 && get_ready(sel) !== 1'b1; i++) @(negedge sys_clk);
        n_vec++;
        if (get_ready(sel) !== 1'b1) begin
            n_err++;
            $display("FAIL send_%0d_%h: tx_ready got %b, required 1 within 5000 cycles",
                     sel, d, get_ready(sel));
        end
        @(negedge sys_clk);
        if (sel != 0) tx_valid2 = 1'b0;
        else          tx_valid1 = 1'b0;
    endtask

    // Checks every cycle of one frame against a hand-built bit pattern:
    // w[0] start, w[8:1] data LSB first, then parity (if built in), then stops.
    task automatic check_frame(input int sel, input logic [7:0] d, input logic par,
                               input bit wait_start, input bit expect_idle,
                               input string name);
        logic [12:0] w;
        int          nbits;
        bit          found;
        bit          bad;
        logic        bad_val;
        logic        bad_busy;
        nbits = 9 + PAR + ((sel != 0) ? 2 : 1);
        w = '1;
        w[0] = 1'b0;
        w[8:1] = d;
        if (PAR == 1) w[9] = par;
        if (wait_start) begin
            found = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if (get_tx(sel) === 1'b0) begin
                    found = 1'b1;
                    break;
                end
                @(negedge sys_clk);
            end
            n_vec++;
            if (!found) begin
                n_err++;
                $display("FAIL %s_start: tx got %b, required 0 within 3000 cycles",
                         name, get_tx(sel));
                return;
            end
        end
        for (int k = 0; k < nbits; k++) begin
            bad = 1'b0;
            bad_val = w[k];
            bad_busy = 1'b1;
            for (int j = 0; j < TICK; j++) begin
                if (get_tx(sel) !== w[k] || get_busy(sel) !== 1'b1) begin
                    bad = 1'b1;
                    bad_val = get_tx(sel);
                    bad_busy = get_busy(sel);
                end
                if (k == 0 && j == 1) begin
                    n_vec++;
                    if (get_ready(sel) !== 1'b1) begin
                        n_err++;
                        $display("FAIL %s_ready_after_start: tx_ready got %b, required 1",
                                 name, get_ready(sel));
                    end
                end
                @(negedge sys_clk);
            end
            n_vec++;
            if (bad) begin
                n_err++;
                $display("FAIL %s_bit%0d: tx got %b busy got %b, required tx %b busy 1",
                         name, k, bad_val, bad_busy, w[k]);
            end
        end
        if (expect_idle) begin
            n_vec++;
            if (get_busy(sel) !== 1'b0 || get_tx(sel) !== 1'b1) begin
                n_err++;
                $display("FAIL %s_end: tx got %b busy got %b, required tx 1 busy 0",
                         name, get_tx(sel), get_busy(sel));
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tx_valid1 = 1'b1;
        tx_data1 = 8'h00;
        repeat (5) @(negedge sys_clk);
        n_vec++;
        if (tx1 !== 1'b1) begin
            n_err++; $display("FAIL reset_tx: got %b, required 1", tx1);
        end
        n_vec++;
        if (tx_ready1 !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b, required 1", tx_ready1);
        end
        n_vec++;
        if (tx_busy1 !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b, required 0", tx_busy1);
        end
        n_vec++;
        if (tx2 !== 1'b1 || tx_ready2 !== 1'b1 || tx_busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_dut2: tx/ready/busy got %b%b%b, required 110",
                     tx2, tx_ready2, tx_busy2);
        end
        reset_n = 1'b1;
        @(negedge sys_clk);
        n_vec++;
        if (tx_ready1 !== 1'b0) begin
            n_err++; $display("FAIL reset_accept: tx_ready got %b, required 0", tx_ready1);
        end
        tx_valid1 = 1'b0;
        check_frame(0, 8'h00, 1'b0, 1'b1, 1'b1, "frame_00");
    endtask

    task automatic test_single();
        send(0, 8'hA5);
        check_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, "frame_a5");
    endtask

    task automatic test_back_to_back();
        send(0, 8'h55);
        fork
            begin
                check_frame(0, 8'h55, 1'b0, 1'b1, 1'b0, "b2b_55");
                check_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, "b2b_c3");
            end
            begin
                repeat (600) @(negedge sys_clk);
                send(0, 8'hC3);
            end
        join
    endtask

    task automatic test_parity();
        send(0, 8'h07);
        check_frame(0, 8'h07, 1'b1, 1'b1, 1'b1, "parity_07");
        send(0, 8'h03);
        check_frame(0, 8'h03, 1'b0, 1'b1, 1'b1, "parity_03");
    endtask

    task automatic test_reset_midframe();
        bit stray;
        send(0, 8'hFF);
        send(0, 8'h3C);
        repeat (5 * TICK) @(negedge sys_clk);
        n_vec++;
        if (tx_ready1 !== 1'b0 || tx_busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_pre: ready/busy got %b%b, required 01", tx_ready1, tx_busy1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (tx1 !== 1'b1 || tx_busy1 !== 1'b0 || tx_ready1 !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_async: tx/busy/ready got %b%b%b, required 101",
                     tx1, tx_busy1, tx_ready1);
        end
        @(negedge sys_clk);
        reset_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (tx1 !== 1'b1 || tx_busy1 !== 1'b0) stray = 1'b1;
            @(negedge sys_clk);
        end
        n_vec++;
        if (stray) begin
            n_err++; $display("FAIL midreset_quiet: line activity seen, required idle");
        end
        n_vec++;
        if (tx_ready1 !== 1'b1) begin
            n_err++; $display("FAIL midreset_ready: got %b, required 1", tx_ready1);
        end
    endtask

    task automatic test_two_stop();
        bit ready_seen;
        send(1, 8'h81);
        fork
            begin
                check_frame(1, 8'h81, 1'b0, 1'b1, 1'b0, "stop2_81");
                check_frame(1, 8'h42, 1'b0, 1'b0, 1'b1, "stop2_42");
            end
            begin
                repeat (600) @(negedge sys_clk);
                send(1, 8'h42);
                // Holding is full: this offer must be ignored.
                tx_data2 = 8'hFF;
                tx_valid2 = 1'b1;
                ready_seen = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    if (tx_ready2 !== 1'b0) ready_seen = 1'b1;
                    @(negedge sys_clk);
                end
                tx_valid2 = 1'b0;
                n_vec++;
                if (ready_seen) begin
                    n_err++; $display("FAIL stop2_hold_full: tx_ready went 1, required 0");
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_reset_midframe();
        test_two_stop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter directly downstream of the baud tick generator; consumes its one-cycle baud_tick (115200 Hz at 25 MHz sys_clk) and serialises bytes onto the tx line. The frame format is:
- one start bit (low);
- DATA_BITS data bits, LSB first;
- an optional parity bit;
- STOP_BITS stop bits (high).

A one-entry holding register in front of the shift register allows back-to-back frames with no idle gap. The upstream byte source (pattern-match result logic) drives a valid/ready handshake.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8 legal).
- STOP_BITS, 1, stop bits per frame (1 or 2 legal).

Ports:
- sys_clk  input  1  system clock, 25 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- baud_tick  input  1  single-cycle pulse, one per bit period, from the baud generator.
- tx_data  input  DATA_BITS  byte to send; sampled on acceptance.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register empty; a transfer occurs on a sys_clk edge with tx_valid && tx_ready.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  a frame is on the line (state != IDLE).

Behaviour:
- Reset (async assert, sync release):
  - tx=1, tx_ready=1, tx_busy=0;
  - holding register cleared, state=IDLE, counters=0.
  - Reset mid-frame aborts the frame; tx returns high immediately; any held byte is discarded.
- Handshake:
  - On acceptance, tx_data is written to the holding register and tx_ready goes 0 the next cycle.
  - tx_ready is a registered flag equal to "holding empty". It rises the cycle after the holding byte moves to the shift register.
  - tx_valid without tx_ready is ignored; no data loss, no error.
- Timing rule: all state/tx changes occur only on sys_clk edges where baud_tick=1. Every bit therefore lasts exactly one tick interval (217 cycles).
- States:
  - IDLE: tx=1. On baud_tick with holding full: load shifter, empty holding, tx<=0, go START.
  - START: on baud_tick, tx<=shifter[0], bit_cnt<=0, go DATA.
  - DATA: on each baud_tick:
    - if bit_cnt<DATA_BITS-1: shift right, tx<=next bit, bit_cnt++;
    - else go PARITY when enabled (tx<=parity), otherwise go STOP (tx<=1, stop_cnt<=0).
  - PARITY (feature only): on baud_tick, tx<=1, go STOP.
  - STOP: on baud_tick:
    - if stop_cnt<STOP_BITS-1: stop_cnt++, tx stays 1;
    - else if holding full: load shifter, tx<=0, go START (back-to-back, no gap);
    - else go IDLE.
- Latency: a byte accepted while IDLE starts its start bit at the first baud_tick at least one cycle after acceptance. A byte accepted during a frame starts at the final stop-bit tick boundary.
- Acceptance in the same cycle as baud_tick while IDLE: byte is registered. Frame start waits for the next baud_tick; holding is not read combinationally.
- baud_tick asserted during reset: ignored.
- tx_busy is registered; it is 1 from the start-bit edge through the end of the last stop bit.
- Frame length = 1 + DATA_BITS + P + STOP_BITS ticks, where P = 1 with parity, 0 without.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: PARITY state is compiled in and emits an even parity bit (XOR of the DATA_BITS data bits) between the last data bit and the first stop bit. Frame = 11 ticks for 8N1-equivalent settings.
- Undefined: no PARITY state or parity logic; DATA goes straight to STOP. Frame = 10 ticks for DATA_BITS=8, STOP_BITS=1.

Test Plan:
- Reset with tx_valid=1 held → tx=1, tx_ready=1, tx_busy=0; after release, tx_data=8'h00 accepted, tx_ready=0 next cycle.
- Send 8'hA5, no parity, tick every 217 cycles → line shows 0,1,0,1,0,0,1,0,1,1, each bit exactly 217 cycles; tx_busy spans 2170 cycles; tx_ready back to 1 one cycle after start bit begins.
- Send 8'h55 then 8'hC3 back-to-back (second accepted mid-frame) → start bit of 8'hC3 begins on the same tick that ends 8'h55's stop bit; tx never high for more than one stop bit between frames.
- UART_TX_PARITY_EN defined, send 8'h07 → parity bit = 1, 11-tick frame; send 8'h03 → parity bit = 0.
- Assert reset_n=0 during data bit 4 of 8'hFF with a held byte pending → tx=1 asynchronously; after release no frame transmits until new data; tx_ready=1.
- STOP_BITS=2, send 8'h81 → two high stop ticks before IDLE; tx_valid asserted with tx_ready=0 does not change held byte.
